// File: rtl/if_fetch_pkg.sv
// Shared CPU definitions for the fetch stage: reset PC, the nop word,
// the fetch FSM encoding and a debug view of the fetch state.
package if_fetch_pkg;

    // Address of the first instruction fetched after reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Word presented to decode when no instruction is held (bubble).
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Byte increment between sequential instructions.
    localparam logic [31:0] PC_STEP = 32'd4;

    // Fetch FSM encoding.
    //   FS_REQ  : request on the memory port, address = PC
    //   FS_WAIT : request accepted, read data still pending
    //   FS_HOLD : instruction buffered and presented to decode
    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_e;

    // Internal state exposed for checkers and debug.
    typedef struct packed {
        fetch_state_e state;
        logic         redir_pend;
        logic [31:0]  redir_addr;
    } fetch_dbg_t;

    // Every control-transfer target is forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: one-outstanding-request memory port, a single
// instruction buffer feeding the F_D register, and a one-deep redirect
// latch that implements the branch delay slot.
//
// Memory handshake: a request transfers on a rising edge where
// imem_req=1 and imem_ready=1. Read data transfers on any rising edge
// where imem_rvalid=1 while a request is in flight; it may arrive in the
// same cycle the request is accepted. imem_rvalid is ignored at all other
// times. imem_req is never raised while a request is outstanding.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        npc_sel,
    input  logic [31:0] npc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_F,
    output logic [31:0] INSTR_F,
    output logic        fetch_busy,
    output fetch_dbg_t  dbg
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_q, buf_d;
    logic         redir_pend_q, redir_pend_d;
    logic [31:0]  redir_addr_q, redir_addr_d;
    logic         imem_req_q, imem_req_d;
    logic [31:0]  instr_f_q, instr_f_d;
    logic         fetch_busy_q, fetch_busy_d;

    logic         consume;
    logic         redir_take;
    logic [31:0]  next_pc;

    // Next PC: a redirect on the consume edge wins, then a parked redirect,
    // otherwise sequential (wraps naturally at 2^32).
    always_comb begin
        consume    = (state_q == FS_HOLD) && !stall;
        redir_take = npc_sel && !stall;
        if (redir_take) begin
            next_pc = word_align(npc_target);
        end else if (redir_pend_q) begin
            next_pc = redir_addr_q;
        end else begin
            next_pc = pc_q + PC_STEP;
        end
    end

    // FSM, PC, buffer and redirect latch next-state logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        redir_pend_d = redir_pend_q;
        redir_addr_d = redir_addr_q;

        case (state_q)
            FS_REQ: begin
                if (imem_ready) begin
                    if (imem_rvalid) begin
                        // Zero-latency memory answers in the accept cycle.
                        buf_d   = imem_rdata;
                        state_d = FS_HOLD;
                    end else begin
                        state_d = FS_WAIT;
                    end
                end
            end
            FS_WAIT: begin
                if (imem_rvalid) begin
                    buf_d   = imem_rdata;
                    state_d = FS_HOLD;
                end
            end
            FS_HOLD: begin
                // Stall freezes PC, buffer and state together.
                if (!stall) begin
                    pc_d    = next_pc;
                    state_d = FS_REQ;
                end
            end
            default: begin
                state_d = FS_REQ;
            end
        endcase

        // The instruction in F is the delay slot: a redirect that does not
        // coincide with its consumption is parked until it is consumed.
        if (consume) begin
            redir_pend_d = 1'b0;
        end else if (redir_take) begin
            redir_pend_d = 1'b1;
            redir_addr_d = word_align(npc_target);
        end
    end

    // Registered outputs follow the state being entered.
    always_comb begin
        imem_req_d   = (state_d == FS_REQ);
        instr_f_d    = (state_d == FS_HOLD) ? buf_d : NOP_WORD;
        fetch_busy_d = (state_d != FS_HOLD);
    end

    // All fetch state and registered outputs; async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FS_REQ;
            pc_q         <= RESET_PC;
            buf_q        <= NOP_WORD;
            redir_pend_q <= 1'b0;
            redir_addr_q <= 32'h0000_0000;
            imem_req_q   <= 1'b1;
            instr_f_q    <= NOP_WORD;
            fetch_busy_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            redir_pend_q <= redir_pend_d;
            redir_addr_q <= redir_addr_d;
            imem_req_q   <= imem_req_d;
            instr_f_q    <= instr_f_d;
            fetch_busy_q <= fetch_busy_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign PC_F       = pc_q;
    assign INSTR_F    = instr_f_q;
    assign fetch_busy = fetch_busy_q;

    assign dbg.state      = state_q;
    assign dbg.redir_pend = redir_pend_q;
    assign dbg.redir_addr = redir_addr_q;

endmodule
